// File: rtl/wb_pkg.sv
// Shared types and bus widths for the Wishbone master adapter.
package wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    localparam int WB_ADR_W               = 32;
    localparam int WB_DAT_W               = 32;
    localparam int WB_SEL_W               = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/wb_timeout_counter.sv
// Cycle counter for an in-flight bus cycle; flags the last allowed wait cycle.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST_COUNT = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] ONE        = TMO_W'(1);

    logic [TMO_W-1:0] count;

    // Clear has priority so every new cycle starts counting from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end else begin
            count <= count;
        end
    end

    assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/wb_master_adapter.sv
// Wishbone B4 classic master: one registered single-transfer cycle per CPU request,
// terminated by err, ack or timeout (in that priority).
module wb_master_adapter
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TMO_W          = 8
) (
    input  logic                clk_i,
    input  logic                rst,
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [WB_ADR_W-1:0] cpu_addr_i,
    input  logic [WB_DAT_W-1:0] cpu_wdata_i,
    input  logic [WB_SEL_W-1:0] cpu_be_i,
    output logic [WB_DAT_W-1:0] cpu_rdata_o,
    output logic                cpu_ready_o,
    output logic                cpu_err_o,
    output logic                cpu_busy_o,
    output logic [WB_ADR_W-1:0] wb_adr_o,
    output logic [WB_DAT_W-1:0] wb_dat_o,
    output logic [WB_SEL_W-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [WB_DAT_W-1:0] wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);

    state_t state;
    logic   tmo_expired;
    logic   unused_addr_bits;

    // Byte offset is dropped: the bus is word-addressed and lanes come from wb_sel_o.
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TMO_W         (TMO_W)
    ) u_tmo (
        .clk    (clk_i),
        .rst    (rst),
        .clr    (state == IDLE),
        .en     (state == BUS),
        .expired(tmo_expired)
    );

    // Request/response FSM with all bus and CPU outputs registered.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cpu_rdata_o <= '0;
            cpu_ready_o <= 1'b0;
            cpu_err_o   <= 1'b0;
            cpu_busy_o  <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            wb_we_o     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
        end else begin
            cpu_ready_o <= 1'b0;
            cpu_err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req_i) begin
                        wb_adr_o   <= {cpu_addr_i[WB_ADR_W-1:2], 2'b00};
                        wb_dat_o   <= cpu_wdata_i;
                        wb_sel_o   <= cpu_be_i;
                        wb_we_o    <= cpu_we_i;
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        cpu_busy_o <= 1'b1;
                        state      <= BUS;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUS: begin
                    if (wb_err_i || wb_ack_i || tmo_expired) begin
                        // A store ack leaves the last load data in place.
                        if (wb_err_i || !wb_ack_i) begin
                            cpu_err_o   <= 1'b1;
                            cpu_rdata_o <= '0;
                        end else if (!wb_we_o) begin
                            cpu_rdata_o <= wb_dat_i;
                        end else begin
                            cpu_rdata_o <= cpu_rdata_o;
                        end
                        cpu_ready_o <= 1'b1;
                        cpu_busy_o  <= 1'b0;
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        state <= BUS;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_adapter.sv
// Directed self-checking bench for wb_master_adapter (timeout shortened to 8 cycles).
module tb_wb_master_adapter;

    logic        clk_i = 1'b0;
    logic        rst;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [3:0]  cpu_be_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_ready_o;
    logic        cpu_err_o;
    logic        cpu_busy_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int checks = 0;
    int errors = 0;
    int cyc_len;

    always #5 clk_i = ~clk_i;

    wb_master_adapter #(.TIMEOUT_CYCLES(8), .TMO_W(8)) dut (
        .clk_i      (clk_i),
        .rst        (rst),
        .cpu_req_i  (cpu_req_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i),
        .cpu_be_i   (cpu_be_i),
        .cpu_rdata_o(cpu_rdata_o),
        .cpu_ready_o(cpu_ready_o),
        .cpu_err_o  (cpu_err_o),
        .cpu_busy_o (cpu_busy_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'h0;
        cpu_wdata_i = 32'h0; cpu_be_i = 4'h0; wb_dat_i = 32'h0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        tick(); tick();
        check("rst_cyc",   {31'h0, wb_cyc_o},    32'h0);
        check("rst_stb",   {31'h0, wb_stb_o},    32'h0);
        check("rst_busy",  {31'h0, cpu_busy_o},  32'h0);
        check("rst_ready", {31'h0, cpu_ready_o}, 32'h0);
        check("rst_rdata", cpu_rdata_o,          32'h0);
        check("rst_adr",   wb_adr_o,             32'h0);
        rst = 1'b0;
        tick();

        // Zero-wait read
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h1000_0006; cpu_be_i = 4'hF;
        tick();
        cpu_req_i = 1'b0;
        check("rd_cyc",   {31'h0, wb_cyc_o},    32'h1);
        check("rd_stb",   {31'h0, wb_stb_o},    32'h1);
        check("rd_busy",  {31'h0, cpu_busy_o},  32'h1);
        check("rd_adr",   wb_adr_o,             32'h1000_0004);
        check("rd_sel",   {28'h0, wb_sel_o},    32'hF);
        check("rd_we",    {31'h0, wb_we_o},     32'h0);
        check("rd_ready_early", {31'h0, cpu_ready_o}, 32'h0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        check("rd_ready", {31'h0, cpu_ready_o}, 32'h1);
        check("rd_err",   {31'h0, cpu_err_o},   32'h0);
        check("rd_rdata", cpu_rdata_o,          32'hDEAD_BEEF);
        check("rd_cyc_drop", {31'h0, wb_cyc_o}, 32'h0);
        check("rd_busy_drop", {31'h0, cpu_busy_o}, 32'h0);
        tick();
        check("rd_ready_1cyc", {31'h0, cpu_ready_o}, 32'h0);

        // Store with 3 wait states
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h2000_0000;
        cpu_wdata_i = 32'h0000_0041; cpu_be_i = 4'h1;
        tick();
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'hFFFF_FFFF;
        cpu_wdata_i = 32'h5555_5555; cpu_be_i = 4'hE;
        for (int i = 0; i < 4; i++) begin
            check("wr_cyc",   {31'h0, wb_cyc_o},    32'h1);
            check("wr_stb",   {31'h0, wb_stb_o},    32'h1);
            check("wr_we",    {31'h0, wb_we_o},     32'h1);
            check("wr_sel",   {28'h0, wb_sel_o},    32'h1);
            check("wr_adr",   wb_adr_o,             32'h2000_0000);
            check("wr_dat",   wb_dat_o,             32'h0000_0041);
            check("wr_ready_wait", {31'h0, cpu_ready_o}, 32'h0);
            if (i == 3) begin
                wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777;
            end
            tick();
        end
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        check("wr_ready", {31'h0, cpu_ready_o}, 32'h1);
        check("wr_err",   {31'h0, cpu_err_o},   32'h0);
        check("wr_rdata_kept", cpu_rdata_o,     32'hDEAD_BEEF);
        check("wr_cyc_drop", {31'h0, wb_cyc_o}, 32'h0);
        tick();
        check("wr_ready_1cyc", {31'h0, cpu_ready_o}, 32'h0);

        // Error and ack together on a load: err wins
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h3000_0008; cpu_be_i = 4'hF;
        tick();
        cpu_req_i = 1'b0;
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h1234_5678;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
        check("er_ready", {31'h0, cpu_ready_o}, 32'h1);
        check("er_err",   {31'h0, cpu_err_o},   32'h1);
        check("er_rdata", cpu_rdata_o,          32'h0);
        check("er_cyc",   {31'h0, wb_cyc_o},    32'h0);
        tick();
        check("er_err_1cyc", {31'h0, cpu_err_o}, 32'h0);

        // Timeout after 8 cycles with no response
        wb_dat_i = 32'hCAFE_0000;
        tick();
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h4000_0000;
        tick();
        cpu_req_i = 1'b0;
        cyc_len = 0;
        while (wb_cyc_o && cyc_len < 20) begin
            if (cpu_ready_o) check("to_ready_early", {31'h0, cpu_ready_o}, 32'h0);
            cyc_len++;
            tick();
        end
        check("to_cyc_len", cyc_len,             32'd8);
        check("to_ready",   {31'h0, cpu_ready_o}, 32'h1);
        check("to_err",     {31'h0, cpu_err_o},   32'h1);
        check("to_rdata",   cpu_rdata_o,          32'h0);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        tick();
        wb_ack_i = 1'b0;
        check("late_ack_ready", {31'h0, cpu_ready_o}, 32'h0);
        check("late_ack_cyc",   {31'h0, wb_cyc_o},    32'h0);
        check("late_ack_rdata", cpu_rdata_o,          32'h0);
        tick();
        check("late_ack_ready2", {31'h0, cpu_ready_o}, 32'h0);

        // Back-to-back loads with the request held high
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h5000_0000; cpu_be_i = 4'hF;
        tick();
        check("b2b_cyc0", {31'h0, wb_cyc_o}, 32'h1);
        check("b2b_adr0", wb_adr_o,          32'h5000_0000);
        wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_0001;
        tick();
        wb_ack_i = 1'b0;
        cpu_addr_i = 32'h5000_0010;
        check("b2b_ready0", {31'h0, cpu_ready_o}, 32'h1);
        check("b2b_rdata0", cpu_rdata_o,          32'hA5A5_0001);
        tick();
        check("b2b_cyc1",   {31'h0, wb_cyc_o},    32'h1);
        check("b2b_adr1",   wb_adr_o,             32'h5000_0010);
        check("b2b_ready1", {31'h0, cpu_ready_o}, 32'h0);
        tick();
        check("b2b_still_bus", {31'h0, wb_cyc_o}, 32'h1);

        // Asynchronous reset mid-cycle
        rst = 1'b1;
        #1;
        check("arst_cyc",   {31'h0, wb_cyc_o},    32'h0);
        check("arst_stb",   {31'h0, wb_stb_o},    32'h0);
        check("arst_busy",  {31'h0, cpu_busy_o},  32'h0);
        check("arst_ready", {31'h0, cpu_ready_o}, 32'h0);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("arst_no_ready", {31'h0, cpu_ready_o}, 32'h0);
        rst = 1'b0;
        cpu_addr_i = 32'h6000_0007;
        tick();
        cpu_req_i = 1'b0;
        check("post_rst_cyc", {31'h0, wb_cyc_o}, 32'h1);
        check("post_rst_adr", wb_adr_o,          32'h6000_0004);
        wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
        tick();
        wb_ack_i = 1'b0;
        check("post_rst_ready", {31'h0, cpu_ready_o}, 32'h1);
        check("post_rst_rdata", cpu_rdata_o,          32'h0BAD_F00D);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_master_adapter.md
Name: wb_master_adapter

Overview:
- Wishbone B4 classic master that converts a single-request CPU load/store port (RV32I core side) into one Wishbone cycle per request.
- Feeds the NoC/interconnect that reaches wb_uart_top and the other Wishbone slaves.
- Registers all bus outputs, handles ack/err responses, and aborts hung cycles with a timeout.
- Single outstanding transaction; no bursts, no pipelined mode.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUS state without ack/err before abort; must be 1..255.
- TMO_W, 8: width of the timeout counter.

Ports:
- clk_i  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active high
- cpu_req_i  in  1  request strobe, sampled in IDLE only
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address
- cpu_wdata_i  in  32  store data
- cpu_be_i  in  4  byte enables
- cpu_rdata_o  out  32  load data, valid with cpu_ready_o
- cpu_ready_o  out  1  one-cycle completion pulse
- cpu_err_o  out  1  one-cycle error flag, coincident with cpu_ready_o
- cpu_busy_o  out  1  high while a cycle is in flight
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte select
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle valid
- wb_stb_o  out  1  strobe
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error

Behaviour:
- Clock and reset: one clock domain, clk_i. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; timeout counter 0. Asserting rst mid-cycle drops wb_cyc_o/wb_stb_o immediately, and no cpu_ready_o is issued for the aborted cycle.
- State machine: two states, IDLE and BUS.
- IDLE:
  - On an edge with cpu_req_i=1, register wb_adr_o={cpu_addr_i[31:2],2'b00}, wb_dat_o=cpu_wdata_i, wb_sel_o=cpu_be_i, wb_we_o=cpu_we_i.
  - On that edge, set wb_cyc_o=wb_stb_o=1, cpu_busy_o=1, clear the timeout counter, and go to BUS.
- BUS:
  - All wb_*_o are held stable.
  - The counter increments each cycle.
- Termination (evaluated at each edge in BUS, in priority order):
  1. wb_err_i=1: cpu_err_o=1, cpu_rdata_o=0.
  2. wb_ack_i=1: on a load, cpu_rdata_o<=wb_dat_i; on a store, cpu_rdata_o is unchanged.
  3. Counter==TIMEOUT_CYCLES-1 with neither ack nor err: treated as an error (cpu_err_o=1, cpu_rdata_o=0).
  - On any termination: cpu_ready_o=1 for exactly one cycle, wb_cyc_o/wb_stb_o/cpu_busy_o<=0, next state IDLE.
  - Simultaneous ack and err: err wins.
- Latency:
  - Request at edge N: wb_cyc_o high from N.
  - A zero-wait slave acks at edge N+1, so cpu_ready_o is high during cycle N+1..N+2.
  - Minimum: 2 cycles request-to-ready.
- Back-to-back: in the ready-pulse cycle the FSM is in IDLE, so cpu_req_i=1 at that edge starts the next cycle with no bubble.
- cpu_req_i while in BUS is ignored; the CPU holds the request until cpu_ready_o.
- Late responses: ack or err arriving in IDLE is ignored.
- cpu_rdata_o holds its value until the next load completes or an error occurs.
- wb_stb_o always equals wb_cyc_o (single-transfer classic cycles).

Decomposition:
- Package wb_pkg:
  - state enum {IDLE, BUS}
  - WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4
  - default TIMEOUT_CYCLES
- Sub-module wb_timeout_counter (clr, en, expired; parameterised by TIMEOUT_CYCLES/TMO_W). The FSM and datapath stay in the top module.

Test Plan:
- Zero-wait read: req addr=0x1000_0006, be=4'hF, slave acks at the first BUS edge with 0xDEADBEEF -> wb_adr_o=0x1000_0004; cpu_ready_o one cycle, 2 cycles after req; cpu_rdata_o=0xDEADBEEF; cpu_err_o=0.
- Write with 3 wait states: addr=0x2000_0000, wdata=0x0000_0041, be=4'h1 -> wb_cyc_o high 4 cycles; wb_we_o=1; wb_sel_o=4'h1; all outputs stable throughout; one ready pulse; cpu_rdata_o unchanged.
- Error response: slave asserts wb_err_i and wb_ack_i together on a load -> cpu_ready_o=1 and cpu_err_o=1 in the same cycle, cpu_rdata_o=0, cyc drops next edge.
- Timeout: TIMEOUT_CYCLES=8, slave never responds -> cyc high exactly 8 cycles, then ready+err pulse; a spurious ack 2 cycles later has no effect.
- Back-to-back plus reset: req held continuously, zero-wait slave -> new cycles start with no idle bubble; rst asserted mid-BUS -> cyc/stb/busy go 0 asynchronously, no ready pulse, next req after reset works normally.
